pulse_decoder: RTL
==================

PULSE_DECODER -- requirements
Module: pulse_decoder

Interface
REQ-001 Parameter MIN_LOW, default 10: minimum accepted PU low-phase width, in sysclk cycles.
REQ-002 Parameter IDLE_TO, default 200: sysclk cycles without an accepted step before a channel is idle.
REQ-003 Parameter POS_W, default 12: signed position width per channel.
REQ-004 Port sysclk  in  1  system clock; the block's only clock.
REQ-005 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port PU  in  6  per-motor step pulse; active-low; idle high.
REQ-007 Port DR  in  6  per-motor direction; 1 = +1 per step, 0 = -1 per step.
REQ-008 Port MF  in  6  per-motor enable; steps are counted only while high.
REQ-009 Port Stop  in  6  per-motor limit switch, active-high.
REQ-010 Port Clr  in  1  one-cycle pulse; clears sticky Glitch and Ovf.
REQ-011 Port Sel  in  3  channel select for Pos; values 6 and 7 select nothing.
REQ-012 Port Pos  out  POS_W  registered position of channel Sel.
REQ-013 Port Moving  out  6  channel has accepted a step within the last IDLE_TO cycles.
REQ-014 Port Done  out  6  one-cycle pulse when Moving falls.
REQ-015 Port Homed  out  6  channel has seen a Stop release since reset.
REQ-016 Port Glitch  out  6  sticky: a PU low phase shorter than MIN_LOW was seen.
REQ-017 Port Ovf  out  6  sticky: position saturated.

Function
REQ-018 PU, DR, MF and Stop each pass through a 2-FF synchronizer; all decisions use the synchronized values.
REQ-019 Each channel runs a 2-state FSM: HIGH and LOW.
- HIGH -> LOW on synchronized PU 1->0; the width counter loads 1.
- LOW: width counter increments and saturates at 255.
- LOW -> HIGH on synchronized PU 0->1.
REQ-020 On the LOW -> HIGH transition, behaviour depends on width and MF:
- width >= MIN_LOW and MF=1: step accepted; position += (DR ? +1 : -1), using DR sampled at that cycle.
- width < MIN_LOW: no step; Glitch[i] is set.
- width >= MIN_LOW and MF=0: no step, no flag.
REQ-021 Position arithmetic is two's complement and saturates at +2^(POS_W-1)-1 and -2^(POS_W-1).
- A step that would exceed either limit leaves the position unchanged and sets Ovf[i].
REQ-022 A synchronized Stop 1->0 edge (limit release) clears the channel position to 0 and sets Homed[i].
- If this coincides with an accepted step, the clear wins and the result is 0.
REQ-023 Idle counter per channel:
- loads 0 on each accepted step;
- otherwise increments while Moving[i]=1;
- Moving[i] rises in the cycle after an accepted step;
- Moving[i] falls when the counter reaches IDLE_TO-1.
REQ-024 Done[i] is high for exactly one cycle, in the cycle Moving[i] falls.
REQ-025 Pos is registered, one cycle after Sel.
- Pos reflects the position update of an accepted step one cycle after that update.
- Sel=6 or 7 gives Pos=0.
REQ-026 Clr clears Glitch and Ovf; a set event in the same cycle as Clr wins.
REQ-027 Latency from a raw PU rising edge to the position update is 3 sysclk cycles: 2 for the synchronizer, 1 for the update.
REQ-028 Channels are fully independent; simultaneous steps on all six channels are all counted.

Reset
REQ-029 While rst_n=0, asynchronously:
- PU synchronizer stages = 1; all other synchronizer stages = 0;
- FSM = HIGH; positions, width counters and idle counters = 0;
- Pos = 0, Moving = 0, Done = 0, Homed = 0, Glitch = 0, Ovf = 0.
REQ-030 A PU held low through reset release produces no step until it first returns high and falls again.
REQ-031 Reset in mid-pulse discards the partial pulse and produces no Done.

Verification
REQ-032 MF[0]=1, DR[0]=1, 5 PU[0] pulses (50 low / 50 high), Sel=0 -> Pos=5, Moving[0]=1, then Done[0] pulse 200 cycles after the last accepted step, Pos holds 5.
REQ-033 Then DR[0]=0, 7 pulses -> Pos=-2 (12'hFFE); with MF[0]=0, 3 further pulses -> Pos stays -2.
REQ-034 A PU[2] low pulse of 4 cycles with MF[2]=1 -> Glitch[2]=1, position unchanged; Clr -> Glitch[2]=0.
REQ-035 Preload +2047 on channel 1 by stepping, then 1 more DR=1 step -> Pos=2047, Ovf[1]=1.
REQ-036 Stop[3] 0->1->0 while the channel is at 30, released in the same cycle as an accepted step -> Pos=0, Homed[3]=1.
REQ-037 rst_n pulled low while PU[4] is low mid-move at position 9 -> all outputs 0 immediately; after release and PU[4] returning high, no step is counted.

Source files
------------

// File: rtl/pulse_decoder.sv
// rtl/pulse_decoder.sv - six-channel step/direction pulse decoder with position, idle and limit tracking
module pulse_decoder #(
  parameter int MIN_LOW = 10,
  parameter int IDLE_TO = 200,
  parameter int POS_W   = 12
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic [5:0]       PU,
  input  logic [5:0]       DR,
  input  logic [5:0]       MF,
  input  logic [5:0]       Stop,
  input  logic             Clr,
  input  logic [2:0]       Sel,
  output logic [POS_W-1:0] Pos,
  output logic [5:0]       Moving,
  output logic [5:0]       Done,
  output logic [5:0]       Homed,
  output logic [5:0]       Glitch,
  output logic [5:0]       Ovf
);

  localparam int IW = $clog2(IDLE_TO + 1);
  localparam logic [POS_W-1:0] POS_MAX   = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic [POS_W-1:0] POS_MIN   = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic [7:0]       MIN_W     = 8'(MIN_LOW);
  localparam logic [IW-1:0]    IDLE_LAST = IW'(IDLE_TO - 1);

  typedef enum logic {S_HIGH, S_LOW} state_e;

  logic [5:0] pu_s1_q, pu_s2_q, dr_s1_q, dr_s2_q, mf_s1_q, mf_s2_q;
  logic [5:0] stop_s1_q, stop_s2_q, stop_prev_q;
  logic [1:0] settle_q;
  logic [5:0] armed_q;
  state_e     state_q [6];
  logic [7:0] width_q [6];
  logic [IW-1:0]    idle_q [6];
  logic [POS_W-1:0] pos_q  [6];
  logic [POS_W-1:0] pos_d  [6];
  logic [POS_W-1:0] pos_out_q;
  logic [5:0] moving_q, done_q, homed_q, glitch_q, ovf_q;

  logic [5:0] pu_fall, pu_rise, accept, ovf_hit, glitch_hit, stop_rel;

  // A falling edge only counts once the channel has seen a real synchronized
  // high since reset, so a PU held low across reset release is ignored.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      pu_fall[i]    = (state_q[i] == S_HIGH) && !pu_s2_q[i] && armed_q[i];
      pu_rise[i]    = (state_q[i] == S_LOW) && pu_s2_q[i];
      accept[i]     = pu_rise[i] && (width_q[i] >= MIN_W) && mf_s2_q[i];
      glitch_hit[i] = pu_rise[i] && (width_q[i] < MIN_W);
      ovf_hit[i]    = accept[i] && (dr_s2_q[i] ? (pos_q[i] == POS_MAX) : (pos_q[i] == POS_MIN));
      stop_rel[i]   = stop_prev_q[i] && !stop_s2_q[i];
      pos_d[i]      = pos_q[i];
      if (stop_rel[i])
        pos_d[i] = '0;
      else if (accept[i] && !ovf_hit[i])
        pos_d[i] = dr_s2_q[i] ? pos_q[i] + 1'b1 : pos_q[i] - 1'b1;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      pu_s1_q     <= '1;
      pu_s2_q     <= '1;
      dr_s1_q     <= '0;
      dr_s2_q     <= '0;
      mf_s1_q     <= '0;
      mf_s2_q     <= '0;
      stop_s1_q   <= '0;
      stop_s2_q   <= '0;
      stop_prev_q <= '0;
      settle_q    <= '0;
      armed_q     <= '0;
      pos_out_q   <= '0;
      moving_q    <= '0;
      done_q      <= '0;
      homed_q     <= '0;
      glitch_q    <= '0;
      ovf_q       <= '0;
      for (int i = 0; i < 6; i++) begin
        state_q[i] <= S_HIGH;
        width_q[i] <= '0;
        idle_q[i]  <= '0;
        pos_q[i]   <= '0;
      end
    end else begin
      pu_s1_q     <= PU;
      pu_s2_q     <= pu_s1_q;
      dr_s1_q     <= DR;
      dr_s2_q     <= dr_s1_q;
      mf_s1_q     <= MF;
      mf_s2_q     <= mf_s1_q;
      stop_s1_q   <= Stop;
      stop_s2_q   <= stop_s1_q;
      stop_prev_q <= stop_s2_q;
      settle_q    <= {settle_q[0], 1'b1};
      for (int i = 0; i < 6; i++) begin
        if (settle_q[1] && pu_s2_q[i])
          armed_q[i] <= 1'b1;
        case (state_q[i])
          S_HIGH: if (pu_fall[i]) begin
            state_q[i] <= S_LOW;
            width_q[i] <= 8'd1;
          end
          S_LOW: begin
            if (pu_rise[i])
              state_q[i] <= S_HIGH;
            else if (width_q[i] != 8'hFF)
              width_q[i] <= width_q[i] + 8'd1;
          end
          default: state_q[i] <= S_HIGH;
        endcase
        pos_q[i] <= pos_d[i];
        if (stop_rel[i])
          homed_q[i] <= 1'b1;
        if (accept[i]) begin
          idle_q[i]   <= '0;
          moving_q[i] <= 1'b1;
          done_q[i]   <= 1'b0;
        end else if (moving_q[i] && idle_q[i] == IDLE_LAST) begin
          moving_q[i] <= 1'b0;
          done_q[i]   <= 1'b1;
        end else begin
          done_q[i] <= 1'b0;
          if (moving_q[i])
            idle_q[i] <= idle_q[i] + 1'b1;
        end
        if (glitch_hit[i])
          glitch_q[i] <= 1'b1;
        else if (Clr)
          glitch_q[i] <= 1'b0;
        if (ovf_hit[i])
          ovf_q[i] <= 1'b1;
        else if (Clr)
          ovf_q[i] <= 1'b0;
      end
      pos_out_q <= (Sel < 3'd6) ? pos_q[Sel] : '0;
    end
  end

  assign Pos    = pos_out_q;
  assign Moving = moving_q;
  assign Done   = done_q;
  assign Homed  = homed_q;
  assign Glitch = glitch_q;
  assign Ovf    = ovf_q;

endmodule
